// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores over a req/ack
// data bus, with misalignment detection, timeout abort and one-cycle writeback.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign,
  output logic        bus_err
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_size;
  logic [1:0]    r_off;
  logic          r_uns;
  logic          r_load;
  logic [31:0]   r_alu;
  logic [4:0]    r_rd;
  logic          r_rw;

  logic        w_mem_op;
  logic        w_illegal;
  logic        w_misal;
  logic        w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  assign w_mem_op  = mem_read | mem_write;
  assign w_illegal = (mem_read & mem_write) | (size == 2'b11);
  assign w_misal   = ((size == 2'b01) & alu_result[0]) |
                     ((size == 2'b10) & (|alu_result[1:0]));
  assign w_go      = valid_in & w_mem_op & ~w_illegal & ~w_misal;

  assign stall = (r_state == S_ACCESS) | ((r_state == S_IDLE) & w_go);

  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        w_be    = '1;
        w_wdata = store_data;
      end
      default: begin
        w_be    = '0;
        w_wdata = '0;
      end
    endcase
  end

  // Lane selection uses the offset latched at accept time, since the
  // upstream address is no longer guaranteed valid while ACCESS waits.
  always_comb begin
    w_byte = '0;
    w_half = '0;
    w_ld   = '0;
    case (r_off)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_ld = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ld = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ld = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_size       <= '0;
      r_off        <= '0;
      r_uns        <= 1'b0;
      r_load       <= 1'b0;
      r_alu        <= '0;
      r_rd         <= '0;
      r_rw         <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            if (!w_mem_op) begin
              wb_valid     <= 1'b1;
              wb_data      <= alu_result;
              wb_rd        <= rd_in;
              wb_reg_write <= reg_write_in;
            end else if (!w_go) begin
              wb_valid     <= 1'b1;
              misalign     <= 1'b1;
              wb_data      <= alu_result;
              wb_rd        <= rd_in;
              wb_reg_write <= 1'b0;
            end else begin
              r_state    <= S_ACCESS;
              r_cnt      <= '0;
              r_size     <= size;
              r_off      <= alu_result[1:0];
              r_uns      <= unsigned_ld;
              r_load     <= mem_read;
              r_alu      <= alu_result;
              r_rd       <= rd_in;
              r_rw       <= reg_write_in;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            r_state  <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= r_rd;
            if (r_load) begin
              wb_data      <= w_ld;
              wb_reg_write <= r_rw;
            end else begin
              wb_data      <= r_alu;
              wb_reg_write <= 1'b0;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= S_IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            bus_err      <= 1'b1;
            wb_data      <= r_alu;
            wb_rd        <= r_rd;
            wb_reg_write <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal cases, then randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  size = '0;
  logic        unsigned_ld = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        reg_write_in = 1'b0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write, misalign, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit ack_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

  function automatic logic legal(input logic r, input logic w, input logic [1:0] sz,
                                 input logic [31:0] addr);
    if (r && w) return 1'b0;
    if (sz == 2'b11) return 1'b0;
    return (addr % nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] rdata, input logic [1:0] off,
                                         input logic [1:0] sz, input logic uns);
    longint unsigned v, range;
    int unsigned n;
    n = nbytes(sz);
    range = 64'd1 << (8 * n);
    v = {32'd0, rdata};
    v = (v >> (8 * off)) % range;
    if (!uns && v >= range / 2) v = v + 64'h1_0000_0000 - range;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    int m;
    m = ((1 << nbytes(sz)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
    logic [31:0] w;
    int unsigned n;
    n = nbytes(sz);
    for (int unsigned i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy = 1'b0;
  int          m_cyc = 0;
  logic [31:0] t_addr, t_sd;
  logic [1:0]  t_size;
  logic        t_uns, t_load, t_rw;
  logic [4:0]  t_rd;
  logic        e_wb_valid = 1'b0, e_mis = 1'b0, e_berr = 1'b0, e_wb_rw = 1'b0;
  logic [31:0] e_wb_data = '0;
  logic [4:0]  e_wb_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_cyc = 0;
      e_wb_valid = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
      e_wb_rw = 1'b0; e_wb_data = '0; e_wb_rd = '0;
    end else begin
      e_wb_valid = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
      if (m_busy) begin
        m_cyc++;
        if (dmem_ack) begin
          m_busy = 1'b0;
          e_wb_valid = 1'b1;
          e_wb_rd = t_rd;
          e_wb_data = t_load ? ld_val(dmem_rdata, t_addr[1:0], t_size, t_uns) : t_addr;
          e_wb_rw = t_load ? t_rw : 1'b0;
        end else if (m_cyc == TO) begin
          m_busy = 1'b0;
          e_wb_valid = 1'b1; e_berr = 1'b1;
          e_wb_rd = t_rd; e_wb_data = t_addr; e_wb_rw = 1'b0;
        end
      end else if (valid_in) begin
        if (!(mem_read || mem_write)) begin
          e_wb_valid = 1'b1; e_wb_data = alu_result; e_wb_rd = rd_in; e_wb_rw = reg_write_in;
        end else if (!legal(mem_read, mem_write, size, alu_result)) begin
          e_wb_valid = 1'b1; e_mis = 1'b1;
          e_wb_data = alu_result; e_wb_rd = rd_in; e_wb_rw = 1'b0;
        end else begin
          m_busy = 1'b1; m_cyc = 0;
          t_addr = alu_result; t_sd = store_data; t_size = size; t_uns = unsigned_ld;
          t_load = mem_read; t_rd = rd_in; t_rw = reg_write_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    e_stall = m_busy || (valid_in && (mem_read || mem_write) &&
                         legal(mem_read, mem_write, size, alu_result));
    chk("stall", stall, e_stall);
    chk("dmem_req", dmem_req, m_busy);
    if (m_busy) begin
      chk("dmem_addr", dmem_addr, t_addr & 32'hFFFF_FFFC);
      chk("dmem_be", dmem_be, exp_be(t_size, t_addr[1:0]));
      chk("dmem_we", dmem_we, !t_load);
      chk("dmem_wdata", dmem_wdata, exp_wdata(t_size, t_sd));
    end
    chk("wb_valid", wb_valid, e_wb_valid);
    chk("misalign", misalign, e_mis);
    chk("bus_err", bus_err, e_berr);
    chk("wb_data", wb_data, e_wb_data);
    chk("wb_rd", wb_rd, e_wb_rd);
    if (e_wb_valid) chk("wb_reg_write", wb_reg_write, e_wb_rw);
  end

  // Random memory responder, also acking while idle.
  initial forever begin
    @(posedge clk); #1;
    if (ack_rand) begin
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // ---------------- directed helpers ----------------
  logic        o_stall0, o_req, o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rdn, input logic rw);
    valid_in = 1'b1; mem_read = r; mem_write = w; size = sz; unsigned_ld = uns;
    alu_result = addr; store_data = sd; rd_in = rdn; reg_write_in = rw;
  endtask

  // Issues one accepted memory op; ack arrives `delay` cycles after the first req cycle.
  task automatic mem_txn(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int delay, input logic [31:0] rdata);
    step();
    drive(r, w, sz, uns, addr, sd, 5'd9, 1'b1);
    @(negedge clk); o_stall0 = stall;
    step(); valid_in = 1'b0;
    @(negedge clk);
    o_req = dmem_req; o_we = dmem_we; o_be = dmem_be; o_addr = dmem_addr; o_wdata = dmem_wdata;
    repeat (delay) step();
    dmem_ack = 1'b1; dmem_rdata = rdata;
    step(); dmem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);      chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_wb_data", wb_data, 0);
    chk("rst_be", dmem_be, 0);        chk("rst_bus_err", bus_err, 0);
    step(); rst = 1'b0;

    // non-memory pass-through
    step(); drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 5'd5, 1'b1);
    @(negedge clk); chk("t1_stall", stall, 0);
    step(); valid_in = 1'b0;
    @(negedge clk);
    chk("t1_wb_valid", wb_valid, 1); chk("t1_wb_data", wb_data, 32'h42);
    chk("t1_wb_rd", wb_rd, 5);       chk("t1_wb_rw", wb_reg_write, 1);

    // lb with ack on the last permitted cycle, then lbu
    mem_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 3, 32'h80FF_0000);
    chk("t2_stall0", o_stall0, 1); chk("t2_be", o_be, 4'b1000);
    chk("t2_addr", o_addr, 32'h100); chk("t2_we", o_we, 0);
    chk("t2_wb_valid", wb_valid, 1); chk("t2_lb", wb_data, 32'hFFFF_FF80);
    chk("t2_bus_err", bus_err, 0);
    mem_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0000);
    chk("t2_lbu", wb_data, 32'h0000_0080);

    // sh
    mem_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 1, 32'h0);
    chk("t3_be", o_be, 4'b1100); chk("t3_wdata", o_wdata, 32'hABCD_ABCD);
    chk("t3_we", o_we, 1);       chk("t3_req", o_req, 1);
    chk("t3_wb_rw", wb_reg_write, 0); chk("t3_wb_data", wb_data, 32'h202);

    // misaligned word, then reserved size
    step(); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd3, 1'b1);
    @(negedge clk); chk("t4_stall", stall, 0);
    step(); valid_in = 1'b0;
    @(negedge clk);
    chk("t4_mis", misalign, 1); chk("t4_wb_rw", wb_reg_write, 0); chk("t4_req", dmem_req, 0);
    step(); drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1);
    step(); valid_in = 1'b0;
    @(negedge clk);
    chk("t4_sz11_mis", misalign, 1); chk("t4_sz11_req", dmem_req, 0);

    // timeout
    step(); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd4, 1'b1);
    step(); valid_in = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dmem_req) n++;
      else break;
    end
    chk("t5_req_cycles", n, TO);
    chk("t5_bus_err", bus_err, 1); chk("t5_wb_valid", wb_valid, 1);
    chk("t5_wb_rw", wb_reg_write, 0);

    // reset mid-access
    step(); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd6, 1'b1);
    step(); valid_in = 1'b0;
    @(negedge clk); chk("t6_req_before", dmem_req, 1);
    step(); rst = 1'b1; #1;
    chk("t6_req_rst", dmem_req, 0); chk("t6_stall_rst", stall, 0);
    repeat (2) begin @(negedge clk); chk("t6_no_wb", wb_valid, 0); end
    step(); rst = 1'b0;
    @(negedge clk); chk("t6_no_wb_after", wb_valid, 0);
    mem_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 0, 32'hDEAD_BEEF);
    chk("t6_lw_valid", wb_valid, 1); chk("t6_lw_data", wb_data, 32'hDEAD_BEEF);

    // randomized traffic
    ack_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      valid_in = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0, 1, 2: begin mem_read = 1'b0; mem_write = 1'b0; end
        3, 4, 5: begin mem_read = 1'b1; mem_write = 1'b0; end
        6, 7, 8: begin mem_read = 1'b0; mem_write = 1'b1; end
        default: begin mem_read = 1'b1; mem_write = 1'b1; end
      endcase
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      unsigned_ld = $urandom_range(0, 1);
      alu_result = $urandom;
      if ($urandom_range(0, 1) != 0) alu_result[1:0] = 2'b00;
      store_data = $urandom;
      rd_in = 5'($urandom);
      reg_write_in = $urandom_range(0, 1);
    end
    step(); rst = 1'b0; valid_in = 1'b0; ack_rand = 1'b0; dmem_ack = 1'b0;
    repeat (TO + 3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
